// File: rtl/sram_axi_lite_arbiter.sv
// -----------------------------------------------------------------------------
// sram_axi_lite_arbiter
//
// Round-robin arbiter that lets N simple request/response clients share one
// AXI-Lite SRAM slave port. Each accepted request becomes exactly one
// AXI-Lite transaction. Only one transaction is in flight at a time, and its
// completion pulse goes back to the client that issued it.
//
// Ports
//   ACLK, ARESETn        clock, synchronous active-low reset
//   req_valid[N]         per-client request valid
//   req_write[N]         per-client 1=write, 0=read
//   req_addr[N*AW]       packed addresses, client i at [i*AW +: AW]
//   req_wdata[N*32]      packed write data, client i at [i*32 +: 32]
//   req_ready[N]         one-hot accept, driven in the IDLE acceptance cycle
//   rsp_valid[N]         one-hot single-cycle completion pulse
//   rsp_rdata, rsp_resp  read data / BRESP-RRESP, held until the next completion
//   M_AW*, M_W*, M_B*,
//   M_AR*, M_R*          AXI-Lite master port (no WSTRB, full-word writes)
// -----------------------------------------------------------------------------
module sram_axi_lite_arbiter #(
    parameter int N  = 2,
    parameter int AW = 32
) (
    input  logic            ACLK,
    input  logic            ARESETn,

    input  logic [N-1:0]    req_valid,
    input  logic [N-1:0]    req_write,
    input  logic [N*AW-1:0] req_addr,
    input  logic [N*32-1:0] req_wdata,
    output logic [N-1:0]    req_ready,
    output logic [N-1:0]    rsp_valid,
    output logic [31:0]     rsp_rdata,
    output logic [1:0]      rsp_resp,

    output logic [AW-1:0]   M_AWADDR,
    output logic            M_AWVALID,
    input  logic            M_AWREADY,
    output logic [31:0]     M_WDATA,
    output logic            M_WVALID,
    input  logic            M_WREADY,
    input  logic [1:0]      M_BRESP,
    input  logic            M_BVALID,
    output logic            M_BREADY,
    output logic [AW-1:0]   M_ARADDR,
    output logic            M_ARVALID,
    input  logic            M_ARREADY,
    input  logic [31:0]     M_RDATA,
    input  logic [1:0]      M_RRESP,
    input  logic            M_RVALID,
    output logic            M_RREADY
);

    localparam int IDW = $clog2(N);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]   grant_q, grant_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             aw_done_q, aw_done_d;
    logic             w_done_q, w_done_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [1:0]       resp_q, resp_d;

    logic             win_found;
    logic [IDW-1:0]   win_idx;

    // First pending requester at or after rr_ptr, wrapping modulo N.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < N; k++) begin
            if (!win_found && req_valid[(int'(rr_ptr_q) + k) % N]) begin
                win_found = 1'b1;
                win_idx   = IDW'((int'(rr_ptr_q) + k) % N);
            end
        end
    end

    // Next-state and output decode. The read/write choice is carried by the
    // state itself, so no separate write flag is kept.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = grant_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;

        req_ready = '0;
        rsp_valid = '0;
        M_AWVALID = 1'b0;
        M_WVALID  = 1'b0;
        M_BREADY  = 1'b0;
        M_ARVALID = 1'b0;
        M_RREADY  = 1'b0;

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    req_ready[win_idx] = 1'b1;
                    grant_d   = win_idx;
                    addr_d    = req_addr[int'(win_idx)*AW +: AW];
                    wdata_d   = req_wdata[int'(win_idx)*32 +: 32];
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = req_write[win_idx] ? WR_REQ : RD_REQ;
                end
            end

            // AW and W launch together; each drops on its own handshake and
            // the handshake cycle already counts as done.
            WR_REQ: begin
                M_AWVALID = !aw_done_q;
                M_WVALID  = !w_done_q;
                if (M_AWREADY && !aw_done_q) begin
                    aw_done_d = 1'b1;
                end
                if (M_WREADY && !w_done_q) begin
                    w_done_d = 1'b1;
                end
                if ((aw_done_q || M_AWREADY) && (w_done_q || M_WREADY)) begin
                    state_d = WR_RESP;
                end
            end

            WR_RESP: begin
                M_BREADY = 1'b1;
                if (M_BVALID) begin
                    resp_d  = M_BRESP;
                    rdata_d = '0;
                    state_d = DONE;
                end
            end

            RD_REQ: begin
                M_ARVALID = 1'b1;
                if (M_ARREADY) begin
                    state_d = RD_RESP;
                end
            end

            RD_RESP: begin
                M_RREADY = 1'b1;
                if (M_RVALID) begin
                    rdata_d = M_RDATA;
                    resp_d  = M_RRESP;
                    state_d = DONE;
                end
            end

            // The pointer moves past the client just served, so it drops to
            // the back of the round-robin order.
            DONE: begin
                rsp_valid[grant_q] = 1'b1;
                rr_ptr_d = (grant_q == IDW'(N - 1)) ? '0 : grant_q + IDW'(1);
                state_d  = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            grant_q   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            grant_q   <= grant_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
        end
    end

    assign M_AWADDR  = addr_q;
    assign M_ARADDR  = addr_q;
    assign M_WDATA   = wdata_q;
    assign rsp_rdata = rdata_q;
    assign rsp_resp  = resp_q;

endmodule
